// File: rtl/ucsbece154b_fetch_unit.sv
// rtl/ucsbece154b_fetch_unit.sv - predicted fetch stage: PC register, direct-mapped BTB with 2-bit counters, F/D register
// Mispredicts are detected from Execute-stage inputs; they redirect the PC and train the BTB.
module ucsbece154b_fetch_unit #(
  parameter int XLEN = 32,
  parameter int BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] PC_START = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF_i,
  input  logic            StallD_i,
  input  logic            FlushD_i,
  output logic [XLEN-1:0] PCF_o,
  input  logic [31:0]     InstrF_i,
  output logic [31:0]     InstrD_o,
  output logic [XLEN-1:0] PCD_o,
  output logic [XLEN-1:0] PCPlus4D_o,
  output logic            PredTakenD_o,
  output logic [XLEN-1:0] PredTargetD_o,
  input  logic            BranchE_i,
  input  logic            TakenE_i,
  input  logic [XLEN-1:0] PCE_i,
  input  logic [XLEN-1:0] PCTargetE_i,
  input  logic            PredTakenE_i,
  input  logic [XLEN-1:0] PredTargetE_i,
  output logic            MispredictE_o,
  output logic [31:0]     BranchCnt_o,
  output logic [31:0]     MispredCnt_o
);

  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  logic [BTB_ENTRIES-1:0]           btbValid;
  logic [BTB_ENTRIES-1:0][TAGW-1:0] btbTag;
  logic [BTB_ENTRIES-1:0][XLEN-1:0] btbTarget;
  logic [BTB_ENTRIES-1:0][1:0]      btbCtr;

  logic [IDXW-1:0] idxF;
  logic [IDXW-1:0] idxE;
  logic [TAGW-1:0] tagF;
  logic [TAGW-1:0] tagE;
  logic            hitF;
  logic            hitE;
  logic            predTakenF;
  logic [XLEN-1:0] pcPlus4F;
  logic [XLEN-1:0] pcPlus4E;
  logic [XLEN-1:0] predTargetF;
  logic [XLEN-1:0] pcNext;

  // Fetch-side lookup reads the pre-edge BTB contents
  assign idxF        = PCF_o[IDXW+1:2];
  assign tagF        = PCF_o[XLEN-1:IDXW+2];
  assign hitF        = btbValid[idxF] && (btbTag[idxF] == tagF);
  assign predTakenF  = hitF && btbCtr[idxF][1];
  assign pcPlus4F    = PCF_o + PC_INC;
  assign predTargetF = predTakenF ? btbTarget[idxF] : pcPlus4F;

  assign idxE     = PCE_i[IDXW+1:2];
  assign tagE     = PCE_i[XLEN-1:IDXW+2];
  assign hitE     = btbValid[idxE] && (btbTag[idxE] == tagE);
  assign pcPlus4E = PCE_i + PC_INC;

  assign MispredictE_o = BranchE_i &&
                         ((TakenE_i != PredTakenE_i) ||
                          (TakenE_i && (PredTargetE_i != PCTargetE_i)));

  // A redirect from Execute wins over a fetch stall
  always_comb begin
    pcNext = predTargetF;
    if (MispredictE_o)
      pcNext = TakenE_i ? PCTargetE_i : pcPlus4E;
    else if (StallF_i)
      pcNext = PCF_o;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      PCF_o <= PC_START;
    else
      PCF_o <= pcNext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btbValid  <= '0;
      btbTag    <= '0;
      btbTarget <= '0;
      btbCtr    <= {BTB_ENTRIES{2'b01}};
    end else if (BranchE_i) begin
      if (hitE) begin
        if (TakenE_i) begin
          if (btbCtr[idxE] != 2'b11)
            btbCtr[idxE] <= btbCtr[idxE] + 2'd1;
          btbTarget[idxE] <= PCTargetE_i;
        end else if (btbCtr[idxE] != 2'b00) begin
          btbCtr[idxE] <= btbCtr[idxE] - 2'd1;
        end
      end else if (TakenE_i) begin
        // Allocation on a taken miss evicts whatever aliased into this slot
        btbValid[idxE]  <= 1'b1;
        btbTag[idxE]    <= tagE;
        btbTarget[idxE] <= PCTargetE_i;
        btbCtr[idxE]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD_o      <= '0;
      PCD_o         <= '0;
      PCPlus4D_o    <= '0;
      PredTakenD_o  <= 1'b0;
      PredTargetD_o <= '0;
    end else if (FlushD_i) begin
      InstrD_o      <= '0;
      PCD_o         <= '0;
      PCPlus4D_o    <= '0;
      PredTakenD_o  <= 1'b0;
      PredTargetD_o <= '0;
    end else if (!StallD_i) begin
      InstrD_o      <= InstrF_i;
      PCD_o         <= PCF_o;
      PCPlus4D_o    <= pcPlus4F;
      PredTakenD_o  <= predTakenF;
      PredTargetD_o <= predTargetF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BranchCnt_o  <= '0;
      MispredCnt_o <= '0;
    end else begin
      if (BranchE_i && (BranchCnt_o != '1))
        BranchCnt_o <= BranchCnt_o + 32'd1;
      if (MispredictE_o && (MispredCnt_o != '1))
        MispredCnt_o <= MispredCnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_fetch_unit.sv
// tb/tb_ucsbece154b_fetch_unit.sv - self-checking bench for ucsbece154b_fetch_unit
// Reference model keeps BTB entries as full branch PCs and uses integer counter arithmetic.
module tb_ucsbece154b_fetch_unit;

  localparam int NE = 16;
  localparam int TAGSHIFT = 2 + $clog2(NE);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF_i = 1'b0, StallD_i = 1'b0, FlushD_i = 1'b0;
  logic [31:0] PCF_o, InstrF_i = '0, InstrD_o, PCD_o, PCPlus4D_o, PredTargetD_o;
  logic        PredTakenD_o;
  logic        BranchE_i = 1'b0, TakenE_i = 1'b0, PredTakenE_i = 1'b0;
  logic [31:0] PCE_i = '0, PCTargetE_i = '0, PredTargetE_i = '0;
  logic        MispredictE_o;
  logic [31:0] BranchCnt_o, MispredCnt_o;

  ucsbece154b_fetch_unit #(.XLEN(32), .BTB_ENTRIES(NE), .PC_START(32'h0)) dut (
    .clk(clk), .reset(reset), .StallF_i(StallF_i), .StallD_i(StallD_i), .FlushD_i(FlushD_i),
    .PCF_o(PCF_o), .InstrF_i(InstrF_i), .InstrD_o(InstrD_o), .PCD_o(PCD_o),
    .PCPlus4D_o(PCPlus4D_o), .PredTakenD_o(PredTakenD_o), .PredTargetD_o(PredTargetD_o),
    .BranchE_i(BranchE_i), .TakenE_i(TakenE_i), .PCE_i(PCE_i), .PCTargetE_i(PCTargetE_i),
    .PredTakenE_i(PredTakenE_i), .PredTargetE_i(PredTargetE_i), .MispredictE_o(MispredictE_o),
    .BranchCnt_o(BranchCnt_o), .MispredCnt_o(MispredCnt_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { bit v; bit [31:0] pc; bit [31:0] tgt; int ctr; } ent_t;
  ent_t        mBtb [NE];
  bit   [31:0] mPC, mInstrD, mPCD, mPCP4D, mPredTgtD, mBrCnt, mMisCnt;
  bit          mPredTakenD;

  function automatic int idxOf(bit [31:0] pc);
    return int'((pc / 4) % NE);
  endfunction

  function automatic bit lookHit(bit [31:0] pc);
    ent_t e;
    e = mBtb[idxOf(pc)];
    return e.v && ((e.pc >> TAGSHIFT) == (pc >> TAGSHIFT));
  endfunction

  function automatic bit lookTaken(bit [31:0] pc);
    return lookHit(pc) && (mBtb[idxOf(pc)].ctr >= 2);
  endfunction

  function automatic bit [31:0] lookTarget(bit [31:0] pc);
    return lookTaken(pc) ? mBtb[idxOf(pc)].tgt : pc + 32'd4;
  endfunction

  function automatic bit modelMis();
    return BranchE_i && ((TakenE_i != PredTakenE_i) || (TakenE_i && (PredTargetE_i != PCTargetE_i)));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NE; i++) mBtb[i] = '{1'b0, 32'h0, 32'h0, 1};
    mPC = 32'h0; mInstrD = 0; mPCD = 0; mPCP4D = 0; mPredTgtD = 0; mPredTakenD = 0;
    mBrCnt = 0; mMisCnt = 0;
  endtask

  // One clock edge of DUT and model; inputs must already be applied.
  task automatic tick();
    bit pt, m;
    bit [31:0] ptg, nxt, instr;
    int j;
    pt = lookTaken(mPC);
    ptg = lookTarget(mPC);
    m = modelMis();
    instr = InstrF_i;
    if (m) nxt = TakenE_i ? PCTargetE_i : PCE_i + 32'd4;
    else if (StallF_i) nxt = mPC;
    else nxt = ptg;
    @(posedge clk);
    if (FlushD_i) begin
      mInstrD = 0; mPCD = 0; mPCP4D = 0; mPredTakenD = 0; mPredTgtD = 0;
    end else if (!StallD_i) begin
      mInstrD = instr; mPCD = mPC; mPCP4D = mPC + 32'd4; mPredTakenD = pt; mPredTgtD = ptg;
    end
    if (BranchE_i) begin
      j = idxOf(PCE_i);
      if (lookHit(PCE_i)) begin
        if (TakenE_i) begin
          mBtb[j].ctr = (mBtb[j].ctr + 1 > 3) ? 3 : mBtb[j].ctr + 1;
          mBtb[j].tgt = PCTargetE_i;
        end else begin
          mBtb[j].ctr = (mBtb[j].ctr - 1 < 0) ? 0 : mBtb[j].ctr - 1;
        end
      end else if (TakenE_i) begin
        mBtb[j] = '{1'b1, PCE_i, PCTargetE_i, 2};
      end
      if (mBrCnt != 32'hFFFF_FFFF) mBrCnt = mBrCnt + 1;
    end
    if (m && mMisCnt != 32'hFFFF_FFFF) mMisCnt = mMisCnt + 1;
    mPC = nxt;
    @(negedge clk);
    InstrF_i = $urandom;
  endtask

  task automatic setE(input logic br, input logic tk, input logic [31:0] pce, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptg);
    BranchE_i = br; TakenE_i = tk; PCE_i = pce; PCTargetE_i = tgt; PredTakenE_i = pt; PredTargetE_i = ptg;
  endtask

  task automatic clearE();
    setE(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Steer fetch to addr through a not-taken mispredict from addr-4.
  task automatic redirect(input logic [31:0] addr);
    setE(1'b1, 1'b0, addr - 32'd4, 32'h0, 1'b1, 32'h0);
    #1;
    tick();
    clearE();
  endtask

  task automatic midReset();
    #2 reset = 1'b0;
    #1 modelReset();
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (PCF_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", PCF_o, 32'h0); end
    vectors++; if (InstrD_o !== 32'h0 || PredTakenD_o !== 1'b0) begin miscompares++; $display("FAIL reset_fd: got %h/%b expected 0/0", InstrD_o, PredTakenD_o); end
    @(negedge clk) reset = 1'b1;
    setE(1'b1, 1'b1, 32'h10, 32'h40, 1'b0, 32'h14);
    #1;
    tick();
    clearE();
    vectors++; if (PCF_o !== 32'h40) begin miscompares++; $display("FAIL pre_reset_pc: got %h expected %h", PCF_o, 32'h40); end
    midReset();
    vectors++; if (PCF_o !== 32'h0) begin miscompares++; $display("FAIL async_reset_pc: got %h expected %h", PCF_o, 32'h0); end
    vectors++; if (InstrD_o !== 32'h0) begin miscompares++; $display("FAIL async_reset_instr: got %h expected 0", InstrD_o); end
    vectors++; if (BranchCnt_o !== 32'h0 || MispredCnt_o !== 32'h0) begin miscompares++; $display("FAIL async_reset_cnt: got %0d/%0d expected 0/0", BranchCnt_o, MispredCnt_o); end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (PCF_o !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_fetch_%0d: got %h expected %h", i, PCF_o, 32'(4 * i)); end
      tick();
    end
    vectors++; if (PCF_o !== 32'h14) begin miscompares++; $display("FAIL btb_cleared: got %h expected %h", PCF_o, 32'h14); end
  endtask

  task automatic test_cold_branch();
    setE(1'b1, 1'b1, 32'h10, 32'h80, 1'b0, 32'h14);
    #1;
    vectors++; if (MispredictE_o !== 1'b1) begin miscompares++; $display("FAIL cold_mispredict: got %b expected 1", MispredictE_o); end
    tick();
    clearE();
    vectors++; if (PCF_o !== 32'h80) begin miscompares++; $display("FAIL cold_redirect: got %h expected %h", PCF_o, 32'h80); end
    vectors++; if (MispredCnt_o !== mMisCnt) begin miscompares++; $display("FAIL cold_miscnt: got %0d expected %0d", MispredCnt_o, mMisCnt); end
    redirect(32'h10);
    vectors++; if (PCF_o !== 32'h10) begin miscompares++; $display("FAIL second_at_branch: got %h expected %h", PCF_o, 32'h10); end
    tick();
    vectors++; if (PCF_o !== 32'h80) begin miscompares++; $display("FAIL second_predicted: got %h expected %h", PCF_o, 32'h80); end
    vectors++; if (PCD_o !== 32'h10 || PredTakenD_o !== 1'b1 || PredTargetD_o !== 32'h80) begin miscompares++; $display("FAIL second_d_regs: got %h/%b/%h expected 10/1/80", PCD_o, PredTakenD_o, PredTargetD_o); end
    setE(1'b1, 1'b1, 32'h10, 32'h80, 1'b1, 32'h80);
    #1;
    vectors++; if (MispredictE_o !== 1'b0) begin miscompares++; $display("FAIL second_no_mispredict: got %b expected 0", MispredictE_o); end
    tick();
    clearE();
  endtask

  task automatic test_counter();
    setE(1'b1, 1'b1, 32'h10, 32'h80, 1'b1, 32'h80);
    #1;
    tick();
    setE(1'b1, 1'b0, 32'h10, 32'h80, 1'b1, 32'h80);
    #1;
    vectors++; if (MispredictE_o !== 1'b1) begin miscompares++; $display("FAIL nt_mispredict: got %b expected 1", MispredictE_o); end
    tick();
    clearE();
    redirect(32'h10);
    tick();
    vectors++; if (PCF_o !== 32'h80 || PredTakenD_o !== 1'b1) begin miscompares++; $display("FAIL ctr10_still_taken: got %h/%b expected 80/1", PCF_o, PredTakenD_o); end
    setE(1'b1, 1'b0, 32'h10, 32'h80, 1'b1, 32'h80);
    #1;
    tick();
    clearE();
    redirect(32'h10);
    tick();
    vectors++; if (PCF_o !== 32'h14 || PredTakenD_o !== 1'b0) begin miscompares++; $display("FAIL ctr01_not_taken: got %h/%b expected 14/0", PCF_o, PredTakenD_o); end
  endtask

  task automatic test_wrong_target();
    setE(1'b1, 1'b1, 32'h10, 32'h80, 1'b0, 32'h14);
    #1;
    tick();
    clearE();
    redirect(32'h10);
    tick();
    vectors++; if (PredTargetD_o !== 32'h80) begin miscompares++; $display("FAIL wt_old_target: got %h expected %h", PredTargetD_o, 32'h80); end
    setE(1'b1, 1'b1, 32'h10, 32'hC0, 1'b1, 32'h80);
    #1;
    vectors++; if (MispredictE_o !== 1'b1) begin miscompares++; $display("FAIL wt_mispredict: got %b expected 1", MispredictE_o); end
    tick();
    clearE();
    vectors++; if (PCF_o !== 32'hC0) begin miscompares++; $display("FAIL wt_redirect: got %h expected %h", PCF_o, 32'hC0); end
    redirect(32'h10);
    tick();
    vectors++; if (PCF_o !== 32'hC0) begin miscompares++; $display("FAIL wt_trained: got %h expected %h", PCF_o, 32'hC0); end
  endtask

  task automatic test_priority();
    StallF_i = 1'b1;
    setE(1'b1, 1'b1, 32'h300, 32'h200, 1'b0, 32'h0);
    #1;
    tick();
    clearE();
    vectors++; if (PCF_o !== 32'h200) begin miscompares++; $display("FAIL redirect_over_stall: got %h expected %h", PCF_o, 32'h200); end
    tick();
    vectors++; if (PCF_o !== 32'h200 || PCD_o !== 32'h200) begin miscompares++; $display("FAIL stallf_hold: got %h/%h expected 200/200", PCF_o, PCD_o); end
    StallF_i = 1'b0; StallD_i = 1'b1;
    tick();
    vectors++; if (PCF_o !== 32'h204 || PCD_o !== 32'h200) begin miscompares++; $display("FAIL stalld_hold: got %h/%h expected 204/200", PCF_o, PCD_o); end
    FlushD_i = 1'b1;
    tick();
    vectors++; if ({InstrD_o, PCD_o, PCPlus4D_o, PredTargetD_o} !== 128'h0 || PredTakenD_o !== 1'b0) begin miscompares++; $display("FAIL flush_over_stall: got %h %h %h %h %b expected all zero", InstrD_o, PCD_o, PCPlus4D_o, PredTargetD_o, PredTakenD_o); end
    FlushD_i = 1'b0; StallD_i = 1'b0;
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    vectors++; if (PCF_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top: got %h expected %h", PCF_o, 32'hFFFF_FFFC); end
    tick();
    vectors++; if (PCF_o !== 32'h0 || PCPlus4D_o !== 32'h0 || PCD_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_zero: got %h/%h/%h expected 0/0/fffffffc", PCF_o, PCPlus4D_o, PCD_o); end
  endtask

  task automatic test_aliasing();
    midReset();
    @(negedge clk) reset = 1'b1;
    setE(1'b1, 1'b1, 32'h10, 32'h80, 1'b0, 32'h14);
    #1;
    tick();
    setE(1'b1, 1'b1, 32'h50, 32'h90, 1'b0, 32'h54);
    #1;
    tick();
    clearE();
    vectors++; if (MispredCnt_o !== 32'd2) begin miscompares++; $display("FAIL alias_miscnt: got %0d expected 2", MispredCnt_o); end
    redirect(32'h10);
    tick();
    vectors++; if (PCF_o !== 32'h14) begin miscompares++; $display("FAIL alias_evicted: got %h expected %h", PCF_o, 32'h14); end
    redirect(32'h50);
    tick();
    vectors++; if (PCF_o !== 32'h90) begin miscompares++; $display("FAIL alias_survivor: got %h expected %h", PCF_o, 32'h90); end
    vectors++; if (MispredCnt_o !== 32'd4 || BranchCnt_o !== 32'd4) begin miscompares++; $display("FAIL alias_counts: got %0d/%0d expected 4/4", MispredCnt_o, BranchCnt_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      BranchE_i = ($urandom_range(0, 9) < 4);
      TakenE_i = $urandom_range(0, 1);
      PCE_i = 32'($urandom_range(0, 31)) * 4;
      PCTargetE_i = 32'($urandom_range(0, 63)) * 4;
      PredTakenE_i = $urandom_range(0, 1);
      PredTargetE_i = $urandom_range(0, 1) ? PCTargetE_i : 32'($urandom_range(0, 63)) * 4;
      StallF_i = ($urandom_range(0, 99) < 15);
      StallD_i = ($urandom_range(0, 99) < 15);
      FlushD_i = ($urandom_range(0, 99) < 10);
      #1;
      vectors++; if (PCF_o !== mPC) begin miscompares++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, PCF_o, mPC); end
      vectors++; if (MispredictE_o !== modelMis()) begin miscompares++; $display("FAIL rnd_mis[%0d]: got %b expected %b", n, MispredictE_o, modelMis()); end
      vectors++; if (InstrD_o !== mInstrD || PCD_o !== mPCD || PCPlus4D_o !== mPCP4D) begin miscompares++; $display("FAIL rnd_fd[%0d]: got %h/%h/%h expected %h/%h/%h", n, InstrD_o, PCD_o, PCPlus4D_o, mInstrD, mPCD, mPCP4D); end
      vectors++; if (PredTakenD_o !== mPredTakenD || PredTargetD_o !== mPredTgtD) begin miscompares++; $display("FAIL rnd_pred[%0d]: got %b/%h expected %b/%h", n, PredTakenD_o, PredTargetD_o, mPredTakenD, mPredTgtD); end
      vectors++; if (BranchCnt_o !== mBrCnt || MispredCnt_o !== mMisCnt) begin miscompares++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, BranchCnt_o, MispredCnt_o, mBrCnt, mMisCnt); end
      tick();
    end
    clearE();
    StallF_i = 1'b0; StallD_i = 1'b0; FlushD_i = 1'b0;
  endtask

  initial begin
    modelReset();
    test_reset();
    test_cold_branch();
    test_counter();
    test_wrong_target();
    test_priority();
    test_wrap();
    test_aliasing();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_fetch_unit.md
# ucsbece154b_fetch_unit

Parametrised fetch stage for the pipelined RISC-V core: PC register, direct-mapped branch target buffer (BTB) with 2-bit saturating predictors, and the F/D pipeline register with stall/flush. It replaces static PC+4 fetch with predicted fetch. Branches and jumps resolve in Execute; this block detects mispredictions there, redirects the PC, and trains the BTB. Flushing of D/E on a mispredict is done by the hazard unit, using `MispredictE_o`.

## Interface
- `XLEN`, 32: PC/instruction-address width.
- `BTB_ENTRIES`, 16: BTB depth; power of 2, ≥2. `IDXW = log2(BTB_ENTRIES)`.
- `PC_START`, 32'h0000_0000: PC value after reset.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `StallF_i` in 1: hold PC.
- `StallD_i` in 1: hold F/D register.
- `FlushD_i` in 1: clear F/D register.
- `PCF_o` out XLEN: fetch PC.
- `InstrF_i` in 32: instruction at `PCF_o`.
- `InstrD_o` out 32: registered instruction.
- `PCD_o` out XLEN: registered PC.
- `PCPlus4D_o` out XLEN: registered PC+4.
- `PredTakenD_o` out 1: registered prediction.
- `PredTargetD_o` out XLEN: registered predicted target.
- `BranchE_i` in 1: instruction in E is a branch or jump.
- `TakenE_i` in 1: resolved direction.
- `PCE_i` in XLEN: PC of the instruction in E.
- `PCTargetE_i` in XLEN: resolved target.
- `PredTakenE_i` in 1: prediction carried to E.
- `PredTargetE_i` in XLEN: predicted target carried to E.
- `MispredictE_o` out 1: combinational redirect request.
- `BranchCnt_o` out 32: resolved branches, saturating.
- `MispredCnt_o` out 32: mispredictions, saturating.

## Operation
- **BTB entry fields:** valid, tag = PC[XLEN-1:IDXW+2], target[XLEN-1:0], ctr[1:0].
- **BTB index:** PC[IDXW+1:2].
- **Lookup (combinational on `PCF_o`):**
  - hit = valid & tag match.
  - PredTakenF = hit & ctr[1].
  - PredTargetF = PredTakenF ? target : PCF_o+4.
- **Mispredict:** `MispredictE_o` = BranchE_i & ((TakenE_i ≠ PredTakenE_i) | (TakenE_i & PredTargetE_i ≠ PCTargetE_i)).
- **Next PC priority:**
  1. `MispredictE_o`: TakenE_i ? PCTargetE_i : PCE_i+4. This overrides `StallF_i`.
  2. `StallF_i`: hold.
  3. Otherwise: PredTargetF.
- **BTB update** (at the clock edge when BranchE_i = 1; index and tag taken from PCE_i):
  - Hit: ctr increments (saturate at 11) if taken, decrements (saturate at 00) if not. Target ← PCTargetE_i if taken.
  - Miss and taken: allocate, overwriting any existing entry. valid=1, tag, target=PCTargetE_i, ctr=10.
  - Miss and not taken: no change.
- **F/D register priority:** FlushD_i > StallD_i > load.
  - Flush: all fields 0, including InstrD=0 and PredTakenD=0.
  - Load: InstrF_i, PCF_o, PCF_o+4, PredTakenF, PredTargetF.
- **Counters:**
  - `BranchCnt_o` +1 per cycle with BranchE_i.
  - `MispredCnt_o` +1 per cycle with `MispredictE_o`.
  - Both saturate at 32'hFFFF_FFFF.
- **Arithmetic:** all PC adds are modulo 2^XLEN. PC+4 wraps to 0 at the top of the address space.

## Timing
- **Reset** (asynchronous assert; deassert sampled on the next `clk` rise):
  - PCF_o = PC_START.
  - All F/D outputs 0.
  - All BTB valid = 0, ctr = 01.
  - Counters 0.
  - MispredictE_o follows its inputs (combinational).
  - Reset mid-operation discards all BTB contents.
- **Lookup:** zero-latency, same cycle as `PCF_o`. The prediction appears on the D outputs one edge later.
- **Redirect:** PC takes the redirect target at the edge where `MispredictE_o` = 1. Penalty is 2 fetch slots (D and E flushed by the hazard unit).
- **Simultaneous update and lookup of the same index:** the lookup uses pre-edge contents. The update is visible from the next cycle.
- **Stall with no mispredict:** PC and the F/D register hold. No BTB read side effects.
- **BTB_ENTRIES = 2:** index is PC[2], tag is PC[XLEN-1:3].

## Test plan
- **Reset:** assert reset low mid-run with PCF=0x40 -> PCF_o = PC_START immediately, InstrD_o = 0, counters 0, then sequential fetch 0x0, 0x4, 0x8.
- **Cold taken branch:** branch at 0x10 to 0x80, BTB cold -> MispredictE_o = 1, next PCF = 0x80, entry allocated with ctr=10. Second encounter -> fetch goes 0x10 then 0x80 with no mispredict.
- **Counter saturation and decay:** same branch taken 3×, then not taken once -> ctr 11 then 10, still predicts taken. A second not-taken -> ctr 01, predicts not taken at the next fetch.
- **Wrong target:** hit predicts 0x80, resolved target 0xC0 -> mispredict, PC = 0xC0, BTB target updated to 0xC0.
- **Priority:** StallF_i = 1 and MispredictE_o = 1 together -> PC takes the redirect. FlushD_i = 1 with StallD_i = 1 -> F/D cleared.
- **Aliasing:** BTB_ENTRIES = 16, taken branches at 0x10 and 0x50 (same index) -> second overwrites first, and the first misses on the next lookup. `MispredCnt_o` increments once per miss-taken event.
